// File: rtl/expr_recognizer.sv
// Streaming recognizer for arithmetic expressions, one ASCII character per
// accepted cycle: multi-digit operands, + - * /, and bounded parenthesis nesting.
module expr_recognizer #(
  parameter int MAX_DIGITS = 1,
  parameter int MAX_DEPTH  = 0,
  parameter int CNT_W      = 8,
  localparam int DEPTH_W   = ($clog2(MAX_DEPTH + 1) > 1) ? $clog2(MAX_DEPTH + 1) : 1,
  localparam int DIG_W     = ($clog2(MAX_DIGITS + 1) > 1) ? $clog2(MAX_DIGITS + 1) : 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   num_cnt
);

  typedef enum logic [1:0] {
    S_OPND  = 2'd0,
    S_NUM   = 2'd1,
    S_CLOSE = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  state_t             state_reg;
  logic [DIG_W-1:0]   dcnt_reg;
  logic [DEPTH_W-1:0] depth_reg;
  logic [CNT_W-1:0]   num_cnt_reg;
  logic               out_reg;
  logic               err_reg;

  logic is_dig, is_op, is_lp, is_rp;

  always_comb begin
    is_dig = (in >= 8'h30) && (in <= 8'h39);
    is_op  = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A) || (in == 8'h2F);
    is_lp  = (in == 8'h28);
    is_rp  = (in == 8'h29);
  end

  // out/err are updated together with the state so they always equal the
  // Moore decode of the registers they accompany.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg   <= S_OPND;
      dcnt_reg    <= '0;
      depth_reg   <= '0;
      num_cnt_reg <= '0;
      out_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else if (in_valid) begin
      case (state_reg)
        S_OPND: begin
          if (is_dig) begin
            state_reg <= S_NUM;
            dcnt_reg  <= DIG_W'(1);
            if (num_cnt_reg != '1)
              num_cnt_reg <= num_cnt_reg + 1'b1;
            out_reg   <= (depth_reg == '0);
          end else if (is_lp && (depth_reg < DEPTH_W'(MAX_DEPTH))) begin
            depth_reg <= depth_reg + 1'b1;
          end else begin
            state_reg <= S_DEAD;
            out_reg   <= 1'b0;
            err_reg   <= 1'b1;
          end
        end
        S_NUM: begin
          if (is_dig && (dcnt_reg < DIG_W'(MAX_DIGITS))) begin
            dcnt_reg <= dcnt_reg + 1'b1;
          end else if (is_op) begin
            state_reg <= S_OPND;
            out_reg   <= 1'b0;
          end else if (is_rp && (depth_reg != '0)) begin
            state_reg <= S_CLOSE;
            depth_reg <= depth_reg - 1'b1;
            out_reg   <= (depth_reg == DEPTH_W'(1));
          end else begin
            state_reg <= S_DEAD;
            out_reg   <= 1'b0;
            err_reg   <= 1'b1;
          end
        end
        S_CLOSE: begin
          if (is_op) begin
            state_reg <= S_OPND;
            out_reg   <= 1'b0;
          end else if (is_rp && (depth_reg != '0)) begin
            depth_reg <= depth_reg - 1'b1;
            out_reg   <= (depth_reg == DEPTH_W'(1));
          end else begin
            state_reg <= S_DEAD;
            out_reg   <= 1'b0;
            err_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg <= S_DEAD;
        end
      endcase
    end
  end

  assign out     = out_reg;
  assign err     = err_reg;
  assign depth   = depth_reg;
  assign num_cnt = num_cnt_reg;

endmodule
